// File: rtl/alu_share_arb.sv
// Two-requester round-robin front end for one shared combinational alu.
// One transaction in flight: IDLE (grant) -> EXEC (alu sampled) -> RESP (hold until accepted).
module alu_share_arb #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [2*OPW-1:0]   req_op,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_err,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [OPW-1:0]     alu_op,
  input  logic [WIDTH-1:0]   alu_c
);

  // state | meaning
  // IDLE  | waiting for a request, winner sees req_ready
  // EXEC  | alu pins driven from the operand registers, alu_c captured at end
  // RESP  | rsp_valid to owner, held until its rsp_ready
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic       rr_ptr;
  logic       owner;
  logic       winner;
  logic       grant;
  logic       illegal;

  always_comb begin
    winner = rr_ptr;
    if (!req_valid[rr_ptr]) winner = ~rr_ptr;
    grant     = (state == IDLE) && (req_valid != 2'b00);
    req_ready = 2'b00;
    if (grant) req_ready[winner] = 1'b1;
    rsp_valid = 2'b00;
    if (state == RESP) rsp_valid[owner] = 1'b1;
  end

  // Opcodes 110 and 111 have no alu function and return an error response.
  assign illegal = (alu_op > OPW'(5));

  // The alu pin registers double as the operand latches, so they simply
  // hold their last values outside EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      owner    <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            alu_a  <= winner ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
            alu_b  <= winner ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
            alu_op <= winner ? req_op[OPW +: OPW]    : req_op[0 +: OPW];
            owner  <= winner;
            rr_ptr <= ~winner;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_data <= illegal ? '0 : alu_c;
          rsp_err  <= illegal;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural alu attached to the alu pins.
module tb_alu_share_arb;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [5:0]  req_op;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_c;

  int checks = 0;
  int errors = 0;

  alu_share_arb #(.WIDTH(32), .OPW(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c)
  );

  always #5 clk = ~clk;

  // Illegal opcodes return garbage so a missing zeroing is visible.
  always_comb begin
    case (alu_op)
      3'b000:  alu_c = alu_a + alu_b;
      3'b001:  alu_c = alu_a - alu_b;
      3'b010:  alu_c = alu_a & alu_b;
      3'b011:  alu_c = alu_a | alu_b;
      3'b100:  alu_c = alu_a >> alu_b[4:0];
      3'b101:  alu_c = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_c = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic txn(input int who, input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] op, input logic [31:0] ed, input logic ee,
                     input string tag);
    logic [1:0] oh;
    oh = (who == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    req_a[who*32 +: 32] = a;
    req_b[who*32 +: 32] = b;
    req_op[who*3 +: 3]  = op;
    req_valid = oh;
    #1 chk({tag, "_grant"}, req_ready, oh);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk({tag, "_exec_rdy"}, req_ready, 2'b00);
    chk({tag, "_alu_a"}, alu_a, a);
    chk({tag, "_alu_b"}, alu_b, b);
    chk({tag, "_alu_op"}, alu_op, op);
    chk({tag, "_exec_rspv"}, rsp_valid, 2'b00);
    @(negedge clk);
    #1;
    chk({tag, "_rspv"}, rsp_valid, oh);
    chk({tag, "_data"}, rsp_data, ed);
    chk({tag, "_err"}, rsp_err, ee);
    rsp_ready = oh;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1 chk({tag, "_done"}, rsp_valid, 2'b00);
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_a = '0; req_b = '0; req_op = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_alu_op", alu_op, 3'b000);
    reset = 1'b0;

    // Single request
    txn(0, 32'd5, 32'd3, 3'b000, 32'd8, 1'b0, "single");

    // Contention from rr_ptr=0: alternating grants
    do_reset();
    @(negedge clk);
    req_a = {32'd3, 32'd10}; req_b = {32'd5, 32'd7}; req_op = {3'b001, 3'b000};
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("cont_grant%0d", k), req_ready, (k % 2) ? 2'b10 : 2'b01);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk($sformatf("cont_rspv%0d", k), rsp_valid, (k % 2) ? 2'b10 : 2'b01);
      chk($sformatf("cont_data%0d", k), rsp_data, (k % 2) ? 32'hFFFF_FFFE : 32'd17);
      @(negedge clk);
    end
    req_valid = 2'b00; rsp_ready = 2'b00;

    // Backpressure on requester 1; non-owner rsp_ready must be ignored
    @(negedge clk);
    req_a[63:32] = 32'h100; req_b[63:32] = 32'h23; req_op[5:3] = 3'b011;
    req_valid = 2'b10;
    #1 chk("bp_grant", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b11; rsp_ready = 2'b01;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_rspv%0d", k), rsp_valid, 2'b10);
      chk($sformatf("bp_data%0d", k), rsp_data, 32'h123);
      chk($sformatf("bp_rdy%0d", k), req_ready, 2'b00);
      @(negedge clk);
    end
    req_valid = 2'b00; rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    chk("bp_done_rspv", rsp_valid, 2'b00);
    @(negedge clk);
    #1 chk("bp_no_repeat", rsp_valid, 2'b00);

    // Shifts and illegal opcodes
    txn(0, 32'h8000_0000, 32'd4, 3'b100, 32'h0800_0000, 1'b0, "srl");
    txn(0, 32'h8000_0000, 32'd4, 3'b101, 32'hF800_0000, 1'b0, "sra");
    txn(1, 32'd1, 32'd2, 3'b111, 32'h0, 1'b1, "ill111");
    txn(0, 32'h0000_F0F0, 32'h0000_FF00, 3'b010, 32'h0000_F000, 1'b0, "and_after_ill");
    txn(1, 32'd9, 32'd9, 3'b110, 32'h0, 1'b1, "ill110");

    // Reset during EXEC after a req0 grant (rr_ptr would otherwise be 1)
    @(negedge clk);
    req_a[31:0] = 32'd5; req_b[31:0] = 32'd3; req_op[2:0] = 3'b000;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00; reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rexec_rspv", rsp_valid, 2'b00);
    chk("rexec_alu_a", alu_a, 32'h0);
    chk("rexec_data", rsp_data, 32'h0);
    reset = 1'b0; req_valid = 2'b11;
    #1 chk("rexec_ptr0", req_ready, 2'b01);
    req_valid = 2'b00; rsp_ready = 2'b11;
    repeat (3) @(negedge clk);
    #1 chk("rexec_no_stale", rsp_valid, 2'b00);
    rsp_ready = 2'b00;

    // Reset during RESP
    @(negedge clk);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1 chk("rresp_pre", rsp_valid, 2'b01);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rresp_rspv", rsp_valid, 2'b00);
    chk("rresp_data", rsp_data, 32'h0);
    chk("rresp_err", rsp_err, 1'b0);
    reset = 1'b0; req_valid = 2'b11;
    #1 chk("rresp_ptr0", req_ready, 2'b01);
    req_valid = 2'b00; rsp_ready = 2'b11;
    repeat (3) @(negedge clk);
    #1 chk("rresp_no_stale", rsp_valid, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
